// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared codes, state encoding and default vectors for the PC unit
package pc_pkg;

  // Request codes on Branch; every other value is a sequential/branch request
  localparam logic [2:0] BR_JR = 3'b111;
  localparam logic [2:0] BR_J  = 3'b011;

  // RUN fetches normally; TRAP is the single bubble cycle after an exception entry
  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;

endpackage

// File: rtl/pc_next_calc.sv
// rtl/pc_next_calc.sv - combinational candidate next-PC values and jr alignment flag
module pc_next_calc #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_address,
  input  logic [25:0]      i_jump_target,
  input  logic [WIDTH-1:0] i_jr_target,
  output logic [WIDTH-1:0] o_seq,
  output logic [WIDTH-1:0] o_br_target,
  output logic [WIDTH-1:0] o_j_target,
  output logic [WIDTH-1:0] o_jr_target,
  output logic             o_jr_misaligned
);

  logic [WIDTH-1:0] w_seq;

  assign w_seq = i_pc + WIDTH'(4);
  assign o_seq = w_seq;

  // Word offset scaled to bytes; the top two offset bits fall off and the sum wraps
  assign o_br_target = w_seq + (i_address << 2);

  // j keeps the region bits of the sequential PC; at WIDTH=28 there are none left
  generate
    if (WIDTH > 28) begin : g_region
      assign o_j_target = {w_seq[WIDTH-1:28], i_jump_target, 2'b00};
    end else begin : g_no_region
      assign o_j_target = {i_jump_target, 2'b00};
    end
  endgenerate

  // Low bits are cleared for the non-trapping path; the flag drives the trap path
  assign o_jr_target     = {i_jr_target[WIDTH-1:2], 2'b00};
  assign o_jr_misaligned = (i_jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with stall, exception entry, eret and jr alignment trap
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter bit               CHECK_ALIGN  = 1'b1
) (
  input  logic             Clk,
  input  logic             PcReSet,
  input  logic             Stall,
  input  logic             PcSel,
  input  logic [2:0]       Branch,
  input  logic [WIDTH-1:0] Address,
  input  logic [25:0]      JumpTarget,
  input  logic [WIDTH-1:0] JrTarget,
  input  logic             Exc,
  input  logic             Eret,
  output logic [WIDTH-1:0] NEWPC,
  output logic [WIDTH-1:0] EPC,
  output logic [WIDTH-1:0] BadVAddr,
  output logic             AdEL,
  output logic             PcValid
);

  pc_state_e        r_state;
  pc_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_pc, r_epc, r_bad;
  logic             r_adel;
  logic [WIDTH-1:0] w_pc_nxt, w_epc_nxt, w_bad_nxt;
  logic             w_adel_nxt;
  logic [WIDTH-1:0] w_seq, w_br_target, w_j_target, w_jr_target;
  logic             w_jr_misaligned;
  logic             w_adel_trap;
  logic             w_enter_trap;

  pc_next_calc #(.WIDTH(WIDTH)) u_next (
    .i_pc            (r_pc),
    .i_address       (Address),
    .i_jump_target   (JumpTarget),
    .i_jr_target     (JrTarget),
    .o_seq           (w_seq),
    .o_br_target     (w_br_target),
    .o_j_target      (w_j_target),
    .o_jr_target     (w_jr_target),
    .o_jr_misaligned (w_jr_misaligned)
  );

  // A misaligned jr only traps if no higher-priority request (Exc, Eret, Stall) claims the cycle
  assign w_adel_trap  = CHECK_ALIGN && !Exc && !Eret && !Stall &&
                        (Branch == BR_JR) && w_jr_misaligned;
  assign w_enter_trap = (r_state == RUN) && (Exc || w_adel_trap);

  // State register
  always_ff @(posedge Clk) begin
    if (PcReSet) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  // Next state: TRAP always falls back to RUN after one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_enter_trap) w_state_nxt = TRAP;
      TRAP:    w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // Next-PC selection by priority; TRAP ignores every request and holds the vector
  always_comb begin
    w_pc_nxt   = r_pc;
    w_epc_nxt  = r_epc;
    w_bad_nxt  = r_bad;
    w_adel_nxt = 1'b0;
    if (r_state == RUN) begin
      if (w_enter_trap) begin
        w_epc_nxt = r_pc;
        w_pc_nxt  = EXC_VECTOR;
        if (w_adel_trap) begin
          w_bad_nxt  = JrTarget;
          w_adel_nxt = 1'b1;
        end
      end else if (Eret) begin
        w_pc_nxt = r_epc;
      end else if (Stall) begin
        w_pc_nxt = r_pc;
      end else if (Branch == BR_JR) begin
        w_pc_nxt = w_jr_target;
      end else if (Branch == BR_J) begin
        w_pc_nxt = w_j_target;
      end else if (PcSel) begin
        w_pc_nxt = w_br_target;
      end else begin
        w_pc_nxt = w_seq;
      end
    end
  end

  // Datapath registers; reset overrides Stall and everything else
  always_ff @(posedge Clk) begin
    if (PcReSet) begin
      r_pc   <= RESET_VECTOR;
      r_epc  <= '0;
      r_bad  <= '0;
      r_adel <= 1'b0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_epc  <= w_epc_nxt;
      r_bad  <= w_bad_nxt;
      r_adel <= w_adel_nxt;
    end
  end

  // Outputs: fetch is invalid only during the trap bubble
  always_comb begin
    NEWPC    = r_pc;
    EPC      = r_epc;
    BadVAddr = r_bad;
    AdEL     = r_adel;
    PcValid  = (r_state == RUN);
  end

endmodule
